// File: rtl/cam_match_ctrl.sv
// Sequencer for the multi-image CAM match array: loads reference images into slots,
// streams a query in match mode, waits for the array to drain and reports the first match.
module cam_match_ctrl #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 24,
    parameter int NO_OF_IMG    = 2,
    parameter int IDX_WIDTH    = 1,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_load,
    input  logic                  cmd_query,
    input  logic [IDX_WIDTH-1:0]  cmd_sel,
    input  logic [ADDR_WIDTH-1:0] cmd_size,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [NO_OF_IMG-1:0]  cam_we,
    output logic                  cam_match_en,
    output logic                  cam_clr,
    output logic [ADDR_WIDTH-1:0] cam_size,
    output logic [ADDR_WIDTH-1:0] cam_addr,
    output logic [DATA_WIDTH-1:0] cam_din,
    input  logic [NO_OF_IMG-1:0]  cam_match,
    output logic                  busy,
    output logic                  done,
    output logic                  hit,
    output logic [IDX_WIDTH-1:0]  hit_idx,
    output logic                  err
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, QUERY, DRAIN, REPORT} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]   size_reg, size_next;
    logic [IDX_WIDTH-1:0]    sel_reg, sel_next;
    logic [DW-1:0]           drain_reg, drain_next;
    logic                    ready_reg, ready_next;
    logic [NO_OF_IMG-1:0]    we_reg, we_next;
    logic                    match_en_reg, match_en_next;
    logic                    clr_reg, clr_next;
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]   din_reg, din_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;
    logic                    hit_reg, hit_next;
    logic [IDX_WIDTH-1:0]    hit_idx_reg, hit_idx_next;
    logic                    err_reg, err_next;
    logic                    handshake;
    logic                    last_pixel;
    logic [IDX_WIDTH-1:0]    lowest_idx;

    assign handshake  = s_valid & ready_reg;
    assign last_pixel = (cnt_reg == size_reg - ADDR_WIDTH'(1));

    // Descending scan so the lowest set bit is the one left standing.
    always_comb begin
        lowest_idx = '0;
        for (int i = NO_OF_IMG - 1; i >= 0; i--) begin
            if (cam_match[i]) lowest_idx = IDX_WIDTH'(i);
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        size_next    = size_reg;
        sel_next     = sel_reg;
        drain_next   = drain_reg;
        we_next      = '0;
        addr_next    = addr_reg;
        din_next     = din_reg;
        done_next    = 1'b0;
        hit_next     = hit_reg;
        hit_idx_next = hit_idx_reg;
        err_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_load) begin
                    if (cmd_size != '0 && int'(cmd_sel) < NO_OF_IMG) begin
                        size_next  = cmd_size;
                        sel_next   = cmd_sel;
                        cnt_next   = '0;
                        state_next = LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (cmd_query) begin
                    if (cmd_size != '0) begin
                        size_next  = cmd_size;
                        state_next = CLEAR;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (handshake) begin
                    we_next   = NO_OF_IMG'(1) << sel_reg;
                    addr_next = cnt_reg;
                    din_next  = s_data;
                    if (last_pixel) begin
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + ADDR_WIDTH'(1);
                    end
                end
            end
            CLEAR: begin
                cnt_next   = '0;
                state_next = QUERY;
            end
            QUERY: begin
                if (handshake) begin
                    addr_next = cnt_reg;
                    din_next  = s_data;
                    if (last_pixel) begin
                        cnt_next   = '0;
                        drain_next = DW'(DRAIN_CYCLES);
                        state_next = DRAIN;
                    end else begin
                        cnt_next = cnt_reg + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_reg == '0) begin
                    hit_next     = |cam_match;
                    hit_idx_next = lowest_idx;
                    done_next    = 1'b1;
                    state_next   = REPORT;
                end else begin
                    drain_next = drain_reg - DW'(1);
                end
            end
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Status outputs are registered against the upcoming state so they line up with it.
        ready_next    = (state_next == LOAD) || (state_next == QUERY);
        match_en_next = (state_next == QUERY) || (state_next == DRAIN);
        clr_next      = (state_next == CLEAR);
        busy_next     = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            size_reg     <= '0;
            sel_reg      <= '0;
            drain_reg    <= '0;
            ready_reg    <= 1'b0;
            we_reg       <= '0;
            match_en_reg <= 1'b0;
            clr_reg      <= 1'b0;
            addr_reg     <= '0;
            din_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            hit_reg      <= 1'b0;
            hit_idx_reg  <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            size_reg     <= size_next;
            sel_reg      <= sel_next;
            drain_reg    <= drain_next;
            ready_reg    <= ready_next;
            we_reg       <= we_next;
            match_en_reg <= match_en_next;
            clr_reg      <= clr_next;
            addr_reg     <= addr_next;
            din_reg      <= din_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            hit_reg      <= hit_next;
            hit_idx_reg  <= hit_idx_next;
            err_reg      <= err_next;
        end
    end

    assign s_ready      = ready_reg;
    assign cam_we       = we_reg;
    assign cam_match_en = match_en_reg;
    assign cam_clr      = clr_reg;
    assign cam_size     = size_reg;
    assign cam_addr     = addr_reg;
    assign cam_din      = din_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign hit          = hit_reg;
    assign hit_idx      = hit_idx_reg;
    assign err          = err_reg;

endmodule
